imem_loader: RTL and testbench

Boot-time instruction-memory writer for the five-stage pipeline. It accepts a framed byte stream over a valid/ready handshake, typically from a UART receiver. It assembles big-endian 32-bit words and writes them sequentially into instruction memory from word address 0. While loading, it holds the pipeline stalled, so the fetch stage only reads memory after the program image is complete.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_word_packer.sv | 43 ++++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam logic [7:0] SyncByteDefault = 8'hA5;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_valid pulses the cycle after
// the 4th byte of a word is shifted in.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        word_end
);

    logic [1:0]  cnt_q;
    logic [23:0] sr_q;
    logic [31:0] word_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            sr_q    <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= shift_en && (cnt_q == 2'd3);
            if (clear) begin
                cnt_q <= 2'd0;
            end else if (shift_en) begin
                cnt_q <= cnt_q + 2'd1;
                sr_q  <= {sr_q[15:0], byte_in};
                if (cnt_q == 2'd3) begin
                    word_q <= {sr_q, byte_in};
                end
            end
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign word_end   = (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes instruction memory from word 0 and stalls the CPU
// while loading. Define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] Capacity = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e StPayloadEnd = StChk;
`else
    localparam state_e StPayloadEnd = StDone;
`endif

    state_e            state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       len_full;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              is_sync;
    logic              clear;
    logic              shift_en;
    logic              word_valid;
    logic              word_end;
    logic [31:0]       word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    assign accept   = in_valid & in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign len_full = {len_q[15:8], in_data};

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            StIdle, StErr: begin
                if (accept && is_sync) begin
                    state_d = StLenHi;
                    clear   = 1'b1;
                end
            end
            StLenHi: begin
                if (accept) state_d = StLenLo;
            end
            StLenLo: begin
                if (accept) begin
                    if ({1'b0, len_full} > Capacity) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StPayloadEnd;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (word_end && (len_q == 16'd1)) state_d = StPayloadEnd;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // len_q doubles as the remaining-word counter once the frame header is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= 16'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                addr_q <= '0;
            end else if (word_valid) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (accept) begin
                if (state_q == StLenHi) len_q[15:8] <= in_data;
                if (state_q == StLenLo) len_q <= len_full;
                if (state_q == StData && word_end) len_q <= len_q - 16'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= 8'd0;
        end else if (clear) begin
            csum_q <= 8'd0;
        end else if (shift_en) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .shift_en   (shift_en),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid),
        .word_end   (word_end)
    );

    assign in_ready   = rst_n & (state_q != StDone);
    assign cpu_hold   = (state_q != StIdle);
    assign load_done  = (state_q == StDone);
    assign load_err   = (state_q == StErr);
    assign imem_we    = word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected writes are queued as frames are sent and
// matched against imem_we strobes. Follows IMEM_LOADER_CHECKSUM_EN like the RTL.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W    (8),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] frame_w[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          d0;
    logic        we_prev  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk_flip = 8'h00;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is transferred.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            ok = in_ready;
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $error("FAIL accept_timeout: observed no transfer, expected byte 0x%0h accepted", b);
        end
    endtask

    task automatic send_frame(input bit gap);
        logic [15:0] n16;
        logic [31:0] w;
        logic [7:0]  bt;
        logic [7:0]  x;
        x   = 8'h00;
        n16 = 16'(frame_w.size());
        send_byte(8'hA5, gap);
        send_byte(n16[15:8], gap);
        send_byte(n16[7:0], gap);
        foreach (frame_w[i]) begin
            w = frame_w[i];
            exp_q.push_back('{addr: 8'(i), data: w});
            for (int k = 3; k >= 0; k--) begin
                bt = w[8*k +: 8];
                x  = x ^ bt;
                send_byte(bt, gap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x ^ chk_flip, gap);
`endif
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                n_checks++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL spurious_we: observed write addr 0x%0h data 0x%0h, expected none",
                           imem_addr, imem_wdata);
                end
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 64'(imem_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(imem_wdata), 64'(mon_e.data));
                end
                check("we_one_cycle", 64'(we_prev), 64'(0));
            end
            if (load_done) done_cnt++;
        end
        we_prev = imem_we;
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
        check("rst_imem_we", 64'(imem_we), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
        check("rst_load_done", 64'(load_done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // Single word, in_valid held high.
        d0 = done_cnt;
        exp_q.push_back('{addr: 8'h00, data: 32'hDEADBEEF});
        send_byte(8'hA5, 1'b0);
        check("t1_hold_after_sync", 64'(cpu_hold), 64'(1));
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        check("t1_we_after_last_byte", 64'(imem_we), 64'(1));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_no_done_before_chk", 64'(load_done), 64'(0));
        send_byte(8'h22, 1'b0);
`endif
        in_valid = 1'b0;
        check("t1_done", 64'(load_done), 64'(1));
        check("t1_hold_in_done", 64'(cpu_hold), 64'(1));
        check("t1_ready_in_done", 64'(in_ready), 64'(0));
        @(negedge clk);
        check("t1_done_pulse", 64'(load_done), 64'(0));
        check("t1_hold_release", 64'(cpu_hold), 64'(0));
        check("t1_done_cnt", 64'(done_cnt - d0), 64'(1));
        check("t1_sb_empty", 64'(exp_q.size()), 64'(0));

        // Leading garbage, then an empty frame.
        d0 = done_cnt;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h12, 1'b0);
        check("t3_garbage_idle", 64'(cpu_hold), 64'(0));
        frame_w.delete();
        send_frame(1'b0);
        check("t3_done", 64'(load_done), 64'(1));
        @(negedge clk);
        check("t3_done_cnt", 64'(done_cnt - d0), 64'(1));

        // Length overflow (257 words) then recovery.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        in_valid = 1'b0;
        check("t4_err", 64'(load_err), 64'(1));
        check("t4_hold_err", 64'(cpu_hold), 64'(1));
        send_byte(8'h33, 1'b0);
        send_byte(8'h5A, 1'b0);
        check("t4_err_stays", 64'(load_err), 64'(1));
        frame_w.delete();
        send_frame(1'b0);
        check("t4_recover_done", 64'(load_done), 64'(1));
        check("t4_recover_err", 64'(load_err), 64'(0));
        @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match, then mismatch, then recovery.
        frame_w = {32'h01020304};
        chk_flip = 8'h00;
        send_frame(1'b0);
        check("t5_chk_done", 64'(load_done), 64'(1));
        @(negedge clk);
        d0 = done_cnt;
        chk_flip = 8'h01;
        send_frame(1'b0);
        check("t5_chk_err", 64'(load_err), 64'(1));
        check("t5_chk_no_done", 64'(load_done), 64'(0));
        @(negedge clk);
        check("t5_done_cnt", 64'(done_cnt - d0), 64'(0));
        chk_flip = 8'h00;
        frame_w.delete();
        send_frame(1'b0);
        check("t5_recover_done", 64'(load_done), 64'(1));
        @(negedge clk);
`endif

        // Full-capacity frame (256 words) fills every address.
        frame_w.delete();
        for (int i = 0; i < 256; i++) frame_w.push_back($urandom);
        send_frame(1'b0);
        check("t7_full_done", 64'(load_done), 64'(1));
        check("t7_full_no_err", 64'(load_err), 64'(0));
        @(negedge clk);
        check("t7_sb_empty", 64'(exp_q.size()), 64'(0));

        // Three words with in_valid toggling.
        frame_w = {32'h11223344, 32'h55667788, 32'h99AABBCC};
        send_frame(1'b1);
        check("t2_done", 64'(load_done), 64'(1));
        @(negedge clk);
        check("t2_sb_empty", 64'(exp_q.size()), 64'(0));

        // Reset mid-frame, then a fresh frame from address 0.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        in_valid = 1'b0;
        check("t6_hold_before_rst", 64'(cpu_hold), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_hold", 64'(cpu_hold), 64'(0));
        check("t6_rst_we", 64'(imem_we), 64'(0));
        check("t6_rst_addr", 64'(imem_addr), 64'(0));
        check("t6_rst_wdata", 64'(imem_wdata), 64'(0));
        check("t6_rst_done", 64'(load_done), 64'(0));
        check("t6_rst_err", 64'(load_err), 64'(0));
        check("t6_rst_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        frame_w = {32'hCAFEF00D, 32'h0BADC0DE};
        send_frame(1'b0);
        check("t6_done", 64'(load_done), 64'(1));
        @(negedge clk);

        repeat (3) @(negedge clk);
        check("final_sb_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
